redundant_compute_scheduler: RTL and testbench
==============================================

// Module: redundant_compute_scheduler
// PURPOSE
//  Shares one redundant-compute wrapper (dual-engine compute with a cross-check) among NUM_REQ requesters.
//  Grants requesters round-robin and issues one job at a time to the wrapper.
//  On a reported mismatch, re-issues the same job up to MAX_RETRY times.
//  Returns the result, error flag and retry count to the owning requester.
// PARAMETERS
//  NUM_REQ      4     number of requesters (>=2)
//  WIDTH        64    job/result data width
//  MAX_RETRY    2     re-issues allowed after mismatch (0 = never retry)
//  TIMEOUT_CYC  1024  WAIT-state watchdog limit (used only with RCS_TIMEOUT_EN)
// PORTS
//  clk            in   1              clock
//  rst            in   1              synchronous reset, active-high
//  req_valid      in   NUM_REQ        per-requester job valid
//  req_ready      out  NUM_REQ        one-hot, 1-cycle grant/accept pulse
//  req_data       in   NUM_REQ*WIDTH  jobs, requester i at [i*WIDTH +: WIDTH]
//  rsp_valid      out  NUM_REQ        one-hot response valid, held until accepted
//  rsp_ready      in   NUM_REQ        per-requester response ready
//  rsp_data       out  WIDTH          result (shared bus, qualified by rsp_valid)
//  rsp_err        out  1              final attempt still mismatched, or timeout
//  rsp_retries    out  $clog2(MAX_RETRY+1)  re-issues performed for this job
//  rsp_timeout    out  1              response produced by watchdog (0 without macro)
//  cw_in_valid    out  1              job to wrapper
//  cw_in_ready    in   1              wrapper accepts job
//  cw_in_data     out  WIDTH          job data to wrapper
//  cw_out_valid   in   1              wrapper result, single-cycle pulse, no backpressure
//  cw_out_ready   out  1              result ready to wrapper (also gates wrapper in_ready)
//  cw_out_data    in   WIDTH          wrapper result (engine A by policy)
//  cw_out_mismatch in  1              engines disagreed, valid with cw_out_valid
//  busy           out  1              state != IDLE
//  fault          out  1              sticky watchdog fault (0 without macro)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr_ptr=0; retry_cnt=0; fault=0. Reset mid-job abandons the job silently.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: if !fault and any req_valid, pick first valid at or after rr_ptr (wrapping).
//    - Pulse req_ready[g] for that cycle, latch req_data[g] and owner=g, retry_cnt=0, rr_ptr<=g+1 mod NUM_REQ.
//    - Go to ISSUE.
//  ISSUE: cw_in_valid=1, cw_in_data=latched job, cw_out_ready=1 (wrapper in_ready needs it).
//    - On cw_in_valid&&cw_in_ready go to WAIT.
//    - A cw_out_valid seen in ISSUE is ignored.
//  WAIT: cw_out_ready=1. On cw_out_valid:
//    - mismatch && retry_cnt<MAX_RETRY: retry_cnt++, go to ISSUE (same job).
//    - otherwise: latch cw_out_data, rsp_err=mismatch, rsp_retries=retry_cnt, go to RESP.
//  RESP: rsp_valid[owner]=1; rsp_data/err/retries stable while held.
//    - No new grant while in RESP. On rsp_ready[owner] go to IDLE.
//  cw_out_ready=0 in IDLE and RESP; wrapper pulses arriving then are dropped.
//  Latency: grant->cw_in_valid 1 cycle; cw_out_valid->rsp_valid 1 cycle. Min job turnaround 4 cycles plus wrapper latency.
//  One job in flight max. Back-to-back grants of same requester allowed only if no other is valid.
// CONFIGURATION
//  RCS_TIMEOUT_EN defined:
//    - wdog counts WAIT cycles, cleared on entering WAIT. Reaching TIMEOUT_CYC -> RESP with rsp_err=1, rsp_timeout=1, fault<=1.
//    - With fault=1, IDLE never grants (stale wrapper results cannot be misattributed). Only rst clears fault.
//  RCS_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; rsp_timeout=0, fault=0.
// STRUCTURE
//  rcs_pkg: st_e enum {S_IDLE,S_ISSUE,S_WAIT,S_RESP}; rsp status struct {err,timeout,retries}.
//  Sub-module rcs_rr_arbiter (NUM_REQ): req vector + ptr -> one-hot grant, index, any.
//  Pure combinational; pointer update stays in the scheduler.
// TESTING
//  1 req_valid[2], data 0x1234; wrapper returns 0xABCD, no mismatch
//    -> cw_in_data=0x1234; rsp_valid[2], rsp_data=0xABCD, err=0, retries=0.
//  2 All 4 req_valid held high from reset, rsp_ready=1 -> grant order 0,1,2,3,0,1.
//  3 MAX_RETRY=2, mismatch, mismatch, match
//    -> 3 cw_in handshakes with identical data; rsp err=0, retries=2.
//    Three mismatches -> err=1, retries=2, data=3rd result.
//  4 rsp_ready[1] low 5 cycles while req 0,3 valid
//    -> rsp_valid[1] and data held stable, req_ready stays 0; grant to 3 one cycle after accept.
//  5 RCS_TIMEOUT_EN, TIMEOUT_CYC=16, wrapper silent
//    -> rsp after 16 WAIT cycles, err=1, timeout=1, fault=1; no further grants; rst clears.
//  6 rst during WAIT, late cw_out_valid pulse after reset
//    -> outputs 0, rr_ptr=0, pulse ignored, no rsp_valid.

Source files
------------

// File: rtl/redundant_compute_scheduler_pkg.sv
// Shared types for the redundant-compute scheduler: FSM states,
// response status bundle and the retry-counter width helper.
package redundant_compute_scheduler_pkg;

   localparam int RCS_RETRY_W = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } st_e;

   typedef struct packed {
      logic                   err;
      logic                   timeout;
      logic [RCS_RETRY_W-1:0] retries;
   } rsp_st_t;

   // Width of a counter holding 0..m, never narrower than 1 bit.
   function automatic int rcs_rw(input int m);
      return (m > 0) ? $clog2(m + 1) : 1;
   endfunction

endpackage

// File: rtl/redundant_compute_scheduler_if.sv
// Bus bundle between requesters, the scheduler and the compute wrapper.
// slave: scheduler side; master: requesters + wrapper side.
interface redundant_compute_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 64,
   parameter int RW      = 2
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [NUM_REQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]         rsp_data;
   logic                     rsp_err;
   logic [RW-1:0]            rsp_retries;
   logic                     rsp_timeout;
   logic                     cw_in_valid;
   logic                     cw_in_ready;
   logic [WIDTH-1:0]         cw_in_data;
   logic                     cw_out_valid;
   logic                     cw_out_ready;
   logic [WIDTH-1:0]         cw_out_data;
   logic                     cw_out_mismatch;

   modport slave (
      input  req_valid, req_data, rsp_ready,
      input  cw_in_ready, cw_out_valid,
      input  cw_out_data, cw_out_mismatch,
      output req_ready, rsp_valid, rsp_data,
      output rsp_err, rsp_retries, rsp_timeout,
      output cw_in_valid, cw_in_data, cw_out_ready
   );

   modport master (
      output req_valid, req_data, rsp_ready,
      output cw_in_ready, cw_out_valid,
      output cw_out_data, cw_out_mismatch,
      input  req_ready, rsp_valid, rsp_data,
      input  rsp_err, rsp_retries, rsp_timeout,
      input  cw_in_valid, cw_in_data, cw_out_ready
   );
endinterface

// File: rtl/redundant_compute_scheduler_rr_arb.sv
// Combinational round-robin pick: first set req_i bit at or after
// ptr_i (wrapping). Ports: req_i, ptr_i -> gnt_o (one-hot), idx_o, any_o.
module redundant_compute_scheduler_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      idx_o,
   output logic               any_o
);
   int j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr_i) + k) % NUM_REQ;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            idx_o    = IW'(j);
            gnt_o[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/redundant_compute_scheduler.sv
// Round-robin scheduler sharing one dual-engine compute wrapper among
// NUM_REQ requesters, re-issuing a job on mismatch up to MAX_RETRY times.
// Ports: clk, rst (sync, active-high), bus (slave modport: req/rsp/cw
// handshakes), busy (not idle), fault (sticky watchdog fault).
// Optional: define RCS_TIMEOUT_EN for a WAIT watchdog of TIMEOUT_CYC cycles.
module redundant_compute_scheduler
   import redundant_compute_scheduler_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH       = 64,
   parameter int MAX_RETRY   = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic rst,
   redundant_compute_scheduler_if.slave bus,
   output logic busy,
   output logic fault
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int RW = rcs_rw(MAX_RETRY);

   st_e              state_q, state_d;
   logic [IW-1:0]    ptr_q, owner_q, idx;
   logic [NUM_REQ-1:0] gnt;
   logic             any;
   logic [WIDTH-1:0] job_q, res_q;
   logic [RW-1:0]    retry_q;
   rsp_st_t          st_q;
   logic             grant, retry, done, tmo;

   redundant_compute_scheduler_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_arb (
      .req_i (bus.req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (idx),
      .any_o (any)
   );

`ifdef RCS_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYC + 1);
   logic [WDW-1:0] wdog_q;
   logic           fault_q;

   // Cleared whenever outside WAIT, so every attempt gets a full budget.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         if (state_q != S_WAIT) wdog_q <= '0;
         else                   wdog_q <= wdog_q + WDW'(1);
         if (tmo) fault_q <= 1'b1;
      end
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      retry   = 1'b0;
      done    = 1'b0;
      tmo     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // A faulted scheduler stops granting so late wrapper
            // results cannot be credited to a new owner.
            if (!rst && !fault && any) begin
               grant   = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.cw_in_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.cw_out_valid) begin
               if (bus.cw_out_mismatch &&
                   int'(retry_q) < MAX_RETRY) begin
                  retry   = 1'b1;
                  state_d = S_ISSUE;
               end else begin
                  done    = 1'b1;
                  state_d = S_RESP;
               end
            end
`ifdef RCS_TIMEOUT_EN
            else if (wdog_q == WDW'(TIMEOUT_CYC - 1)) begin
               tmo     = 1'b1;
               state_d = S_RESP;
            end
`endif
         end
         S_RESP: begin
            if (bus.rsp_ready[owner_q]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         job_q   <= '0;
         res_q   <= '0;
         retry_q <= '0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            job_q   <= bus.req_data[idx*WIDTH +: WIDTH];
            owner_q <= idx;
            retry_q <= '0;
            ptr_q   <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
         end
         if (retry) retry_q <= retry_q + RW'(1);
         if (done) begin
            res_q <= bus.cw_out_data;
            st_q  <= '{err:     bus.cw_out_mismatch,
                       timeout: 1'b0,
                       retries: RCS_RETRY_W'(retry_q)};
         end
         if (tmo) begin
            res_q <= '0;
            st_q  <= '{err:     1'b1,
                       timeout: 1'b1,
                       retries: RCS_RETRY_W'(retry_q)};
         end
      end
   end

   assign bus.req_ready    = grant ? gnt : '0;
   assign bus.cw_in_valid  = (state_q == S_ISSUE);
   assign bus.cw_in_data   = job_q;
   assign bus.cw_out_ready = (state_q == S_ISSUE) ||
                             (state_q == S_WAIT);
   assign bus.rsp_valid    = (state_q == S_RESP) ?
                             (NUM_REQ'(1) << owner_q) : '0;
   assign bus.rsp_data     = res_q;
   assign bus.rsp_err      = st_q.err;
   assign bus.rsp_retries  = RW'(st_q.retries);
   assign bus.rsp_timeout  = st_q.timeout;
   assign busy             = (state_q != S_IDLE);
endmodule

// File: tb/tb_redundant_compute_scheduler.sv
// Directed self-checking bench for redundant_compute_scheduler.
// Wrapper and requesters are driven step by step from one initial block.
module tb_redundant_compute_scheduler;
   import redundant_compute_scheduler_pkg::*;

   localparam int NR = 4;
   localparam int W  = 64;
   localparam int MR = 2;
   localparam int RW = rcs_rw(MR);

   logic clk;
   logic rst;
   logic busy;
   logic fault;
   int   passed = 0;
   int   total  = 0;

   redundant_compute_scheduler_if #(
      .NUM_REQ (NR), .WIDTH (W), .RW (RW)
   ) bus ();

   redundant_compute_scheduler #(
      .NUM_REQ     (NR),
      .WIDTH       (W),
      .MAX_RETRY   (MR),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus.slave),
      .busy  (busy),
      .fault (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic clr();
      bus.req_valid       = '0;
      bus.req_data        = '0;
      bus.rsp_ready       = '0;
      bus.cw_in_ready     = 1'b0;
      bus.cw_out_valid    = 1'b0;
      bus.cw_out_data     = '0;
      bus.cw_out_mismatch = 1'b0;
   endtask

   task automatic do_reset();
      clr();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // In ISSUE: accept the job, check it, move to WAIT.
   task automatic issue(input logic [63:0] d, input string tag);
      bus.cw_in_ready = 1'b1;
      #1;
      chk({tag, "_in_valid"}, 64'(bus.cw_in_valid), 64'd1);
      chk({tag, "_in_data"}, bus.cw_in_data, d);
      tick();
      bus.cw_in_ready = 1'b0;
   endtask

   // In WAIT: single-cycle wrapper result pulse.
   task automatic wrap_ret(input logic [63:0] d, input logic mm);
      bus.cw_out_valid    = 1'b1;
      bus.cw_out_data     = d;
      bus.cw_out_mismatch = mm;
      tick();
      bus.cw_out_valid    = 1'b0;
      bus.cw_out_mismatch = 1'b0;
   endtask

   initial begin
      clr();
      rst = 1'b1;
      tick();
      tick();
      bus.req_valid = 4'hF;
      #1;
      chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
      chk("rst_cw_in_valid", 64'(bus.cw_in_valid), 64'h0);
      chk("rst_cw_out_ready", 64'(bus.cw_out_ready), 64'h0);
      chk("rst_fault", 64'(fault), 64'h0);
      chk("rst_rsp_data", bus.rsp_data, 64'h0);
      bus.req_valid = '0;
      rst = 1'b0;

      // single job, clean result
      bus.req_valid = 4'b0100;
      bus.req_data[2*W +: W] = 64'h1234;
      #1;
      chk("t1_grant", 64'(bus.req_ready), 64'h4);
      tick();
      bus.req_valid = '0;
      bus.cw_out_valid = 1'b1;
      bus.cw_out_data  = 64'hDEAD;
      #1;
      chk("t1_out_ready", 64'(bus.cw_out_ready), 64'h1);
      bus.cw_out_valid = 1'b0;
      issue(64'h1234, "t1");
      chk("t1_busy_wait", 64'(busy), 64'h1);
      bus.cw_out_data = '0;
      wrap_ret(64'hABCD, 1'b0);
      #1;
      chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'h4);
      chk("t1_rsp_data", bus.rsp_data, 64'hABCD);
      chk("t1_rsp_err", 64'(bus.rsp_err), 64'h0);
      chk("t1_rsp_retries", 64'(bus.rsp_retries), 64'h0);
      chk("t1_cw_out_ready_resp", 64'(bus.cw_out_ready), 64'h0);
      bus.rsp_ready = 4'b0100;
      tick();
      bus.rsp_ready = '0;
      #1;
      chk("t1_rsp_drop", 64'(bus.rsp_valid), 64'h0);
      chk("t1_idle", 64'(busy), 64'h0);

      // retries: mismatch, mismatch, match
      do_reset();
      bus.req_valid = 4'b0010;
      bus.req_data[1*W +: W] = 64'h55;
      #1;
      chk("t3a_grant", 64'(bus.req_ready), 64'h2);
      tick();
      bus.req_valid = '0;
      issue(64'h55, "t3a_i0");
      wrap_ret(64'h111, 1'b1);
      issue(64'h55, "t3a_i1");
      wrap_ret(64'h222, 1'b1);
      issue(64'h55, "t3a_i2");
      wrap_ret(64'h333, 1'b0);
      #1;
      chk("t3a_rsp_valid", 64'(bus.rsp_valid), 64'h2);
      chk("t3a_rsp_data", bus.rsp_data, 64'h333);
      chk("t3a_rsp_err", 64'(bus.rsp_err), 64'h0);
      chk("t3a_rsp_retries", 64'(bus.rsp_retries), 64'h2);
      bus.rsp_ready = 4'b0010;
      tick();
      bus.rsp_ready = '0;

      // retries exhausted: three mismatches; pointer now at 2
      bus.req_valid = 4'b0001;
      bus.req_data[0 +: W] = 64'h66;
      #1;
      chk("t3b_grant", 64'(bus.req_ready), 64'h1);
      tick();
      bus.req_valid = '0;
      issue(64'h66, "t3b_i0");
      wrap_ret(64'h555, 1'b1);
      issue(64'h66, "t3b_i1");
      wrap_ret(64'h666, 1'b1);
      issue(64'h66, "t3b_i2");
      wrap_ret(64'h777, 1'b1);
      #1;
      chk("t3b_no_4th_issue", 64'(bus.cw_in_valid), 64'h0);
      chk("t3b_rsp_valid", 64'(bus.rsp_valid), 64'h1);
      chk("t3b_rsp_data", bus.rsp_data, 64'h777);
      chk("t3b_rsp_err", 64'(bus.rsp_err), 64'h1);
      chk("t3b_rsp_retries", 64'(bus.rsp_retries), 64'h2);
      bus.rsp_ready = 4'b0001;
      tick();
      bus.rsp_ready = '0;

      // response backpressure with competing requests
      do_reset();
      bus.req_valid = 4'b0010;
      bus.req_data[1*W +: W] = 64'h4;
      #1;
      chk("t4_grant1", 64'(bus.req_ready), 64'h2);
      tick();
      bus.req_valid = '0;
      issue(64'h4, "t4");
      wrap_ret(64'h4444, 1'b0);
      bus.req_valid = 4'b1001;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t4_hold_valid", 64'(bus.rsp_valid), 64'h2);
         chk("t4_hold_data", bus.rsp_data, 64'h4444);
         chk("t4_no_grant", 64'(bus.req_ready), 64'h0);
         tick();
      end
      bus.rsp_ready = 4'b0010;
      #1;
      chk("t4_accept_no_grant", 64'(bus.req_ready), 64'h0);
      tick();
      bus.rsp_ready = '0;
      #1;
      chk("t4_grant3", 64'(bus.req_ready), 64'h8);
      chk("t4_rsp_gone", 64'(bus.rsp_valid), 64'h0);

      // all requesters busy from reset, zero-latency wrapper
      clr();
      rst = 1'b1;
      bus.req_valid    = 4'hF;
      bus.rsp_ready    = 4'hF;
      bus.cw_in_ready  = 1'b1;
      bus.cw_out_valid = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int n = 0; n < 6; n++) begin
         int c;
         c = 0;
         #1;
         while (bus.req_ready == '0 && c < 8) begin
            tick();
            #1;
            c++;
         end
         chk("t2_grant_order", 64'(bus.req_ready), 64'(1 << (n % 4)));
         tick();
      end

      // reset mid-WAIT, stale wrapper pulse afterwards
      do_reset();
      bus.req_valid = 4'b0001;
      bus.req_data[0 +: W] = 64'h77;
      tick();
      bus.req_valid = '0;
      issue(64'h77, "t6");
      tick();
      tick();
      #1;
      chk("t6_busy_wait", 64'(busy), 64'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_busy", 64'(busy), 64'h0);
      chk("t6_out_ready", 64'(bus.cw_out_ready), 64'h0);
      bus.cw_out_valid = 1'b1;
      bus.cw_out_data  = 64'hBAD;
      tick();
      bus.cw_out_valid = 1'b0;
      #1;
      chk("t6_no_rsp", 64'(bus.rsp_valid), 64'h0);
      chk("t6_idle", 64'(busy), 64'h0);
      chk("t6_rsp_data", bus.rsp_data, 64'h0);
      bus.req_valid = 4'hF;
      #1;
      chk("t6_ptr_zero", 64'(bus.req_ready), 64'h1);

`ifdef RCS_TIMEOUT_EN
      // silent wrapper: watchdog response and sticky fault
      do_reset();
      bus.req_valid = 4'b0100;
      bus.req_data[2*W +: W] = 64'h99;
      #1;
      chk("t5_grant", 64'(bus.req_ready), 64'h4);
      tick();
      bus.req_valid = '0;
      issue(64'h99, "t5");
      for (int c = 0; c < 15; c++) tick();
      #1;
      chk("t5_wait16", 64'(bus.rsp_valid), 64'h0);
      tick();
      #1;
      chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'h4);
      chk("t5_rsp_err", 64'(bus.rsp_err), 64'h1);
      chk("t5_rsp_timeout", 64'(bus.rsp_timeout), 64'h1);
      chk("t5_fault", 64'(fault), 64'h1);
      bus.rsp_ready = 4'b0100;
      tick();
      bus.rsp_ready = '0;
      bus.req_valid = 4'hF;
      #1;
      chk("t5_no_grant0", 64'(bus.req_ready), 64'h0);
      tick();
      tick();
      #1;
      chk("t5_no_grant1", 64'(bus.req_ready), 64'h0);
      chk("t5_idle", 64'(busy), 64'h0);
      chk("t5_fault_sticky", 64'(fault), 64'h1);
      do_reset();
      bus.req_valid = 4'hF;
      #1;
      chk("t5_fault_clr", 64'(fault), 64'h0);
      chk("t5_grant_again", 64'(bus.req_ready), 64'h1);
`else
      // no watchdog: WAIT holds indefinitely
      do_reset();
      bus.req_valid = 4'b0100;
      tick();
      bus.req_valid = '0;
      issue(64'h0, "t5n");
      for (int c = 0; c < 40; c++) tick();
      #1;
      chk("t5n_busy", 64'(busy), 64'h1);
      chk("t5n_no_rsp", 64'(bus.rsp_valid), 64'h0);
      chk("t5n_timeout", 64'(bus.rsp_timeout), 64'h0);
      chk("t5n_fault", 64'(fault), 64'h0);
`endif

      clr();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
